// File: rtl/adpll_ctrl_pkg.sv
// Shared definitions for the ADPLL gain-sweep sequencer: state encoding,
// gain-selector widths and lock-detector defaults.
package adpll_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FLUSH   = 3'd1,
    S_ACQUIRE = 3'd2,
    S_REPORT  = 3'd3,
    S_NEXT    = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  localparam int DEF_SEL_WIDTH   = 4;
  localparam int KP_PAD          = 1;
  localparam int KI_PAD          = 4;
  localparam int DEF_LOCK_THRESH = 4;
  localparam int DEF_LOCK_COUNT  = 1024;

endpackage

// File: rtl/adpll_gain_sweep_if.sv
// Result-record handshake between the gain sweep sequencer and its consumer.
interface adpll_gain_sweep_if #(
  parameter int SEL_WIDTH = 4,
  parameter int CNT_WIDTH = 24
);
  logic                 result_valid_o;
  logic                 result_ready_i;
  logic [SEL_WIDTH-1:0] result_kp_o;
  logic [SEL_WIDTH-1:0] result_ki_o;
  logic [CNT_WIDTH-1:0] result_time_o;
  logic                 result_timeout_o;

  modport master (
    output result_valid_o, result_kp_o, result_ki_o, result_time_o, result_timeout_o,
    input  result_ready_i
  );

  modport slave (
    input  result_valid_o, result_kp_o, result_ki_o, result_time_o, result_timeout_o,
    output result_ready_i
  );
endinterface

// File: rtl/adpll_lock_detect.sv
// Phase-error lock detector: counts consecutive in-window cycles and remembers
// the cycle at which the current in-window run began.
module adpll_lock_detect #(
  parameter int ERR_WIDTH   = 8,
  parameter int LOCK_THRESH = 4,
  parameter int LOCK_COUNT  = 1024,
  parameter int CNT_WIDTH   = 24
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clr,
  input  logic signed [ERR_WIDTH-1:0] error,
  input  logic        [CNT_WIDTH-1:0] cyc,
  output logic        [CNT_WIDTH-1:0] run_start,
  output logic                        lock
);

  localparam int RUN_W = $clog2(LOCK_COUNT + 1);

  logic [RUN_W-1:0] run;
  logic             in_win;

  // One extra bit so the most-negative error maps to a large magnitude
  // instead of wrapping back into the window.
  function automatic logic [ERR_WIDTH:0] abs_err(input logic signed [ERR_WIDTH-1:0] e);
    logic signed [ERR_WIDTH:0] ext;
    ext = {e[ERR_WIDTH-1], e};
    return ext[ERR_WIDTH] ? -ext : ext;
  endfunction

  assign in_win = abs_err(error) <= (ERR_WIDTH+1)'(LOCK_THRESH);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run       <= '0;
      run_start <= '0;
      lock      <= 1'b0;
    end else if (clr) begin
      run       <= '0;
      run_start <= '0;
      lock      <= 1'b0;
    end else if (in_win) begin
      if (run != RUN_W'(LOCK_COUNT))
        run <= run + RUN_W'(1);
      lock <= (run == RUN_W'(LOCK_COUNT - 1));
    end else begin
      run       <= '0;
      run_start <= cyc + CNT_WIDTH'(1);
      lock      <= 1'b0;
    end
  end

endmodule

// File: rtl/adpll_gain_sweep.sv
// Steps the ADPLL kp/ki selectors over a grid, measures lock time at each
// point and reports one record per point over a valid/ready handshake.
module adpll_gain_sweep
  import adpll_ctrl_pkg::*;
#(
  parameter int KP_WIDTH     = DEF_SEL_WIDTH + KP_PAD,
  parameter int KI_WIDTH     = DEF_SEL_WIDTH + KI_PAD,
  parameter int SEL_WIDTH    = DEF_SEL_WIDTH,
  parameter int ERR_WIDTH    = 8,
  parameter int LOCK_THRESH  = DEF_LOCK_THRESH,
  parameter int LOCK_COUNT   = DEF_LOCK_COUNT,
  parameter int FLUSH_CYCLES = 64,
  parameter int CNT_WIDTH    = 24
) (
  input  logic                        fpga_clk_i,
  input  logic                        reset_i,
  input  logic                        start_i,
  input  logic                        abort_i,
  input  logic        [SEL_WIDTH-1:0] kp_last_i,
  input  logic        [SEL_WIDTH-1:0] ki_last_i,
  input  logic signed [ERR_WIDTH-1:0] error_i,
  output logic                        adpll_enable_o,
  output logic        [KP_WIDTH-1:0]  kp_o,
  output logic        [KI_WIDTH-1:0]  ki_o,
  output logic                        busy_o,
  output logic                        done_o,
  adpll_gain_sweep_if.master          result
);

  state_t               state, state_nx;
  logic [SEL_WIDTH-1:0] kp_sel, ki_sel, kp_last, ki_last;
  logic [CNT_WIDTH-1:0] cnt;
  logic [CNT_WIDTH-1:0] run_start;
  logic                 lock;
  logic                 flush_end, cnt_full, ki_wrap, kp_end, sweep_start;

  assign flush_end   = (cnt == CNT_WIDTH'(FLUSH_CYCLES - 1));
  assign cnt_full    = &cnt;
  assign ki_wrap     = (ki_sel >= ki_last);
  assign kp_end      = (kp_sel >= kp_last);
  assign sweep_start = (state == S_IDLE || state == S_DONE) && (state_nx == S_FLUSH);

  assign kp_o = KP_WIDTH'(kp_sel);
  assign ki_o = KI_WIDTH'(ki_sel);

  adpll_lock_detect #(
    .ERR_WIDTH  (ERR_WIDTH),
    .LOCK_THRESH(LOCK_THRESH),
    .LOCK_COUNT (LOCK_COUNT),
    .CNT_WIDTH  (CNT_WIDTH)
  ) u_lock_detect (
    .clk      (fpga_clk_i),
    .rst      (reset_i),
    .clr      (state != S_ACQUIRE),
    .error    (error_i),
    .cyc      (cnt),
    .run_start(run_start),
    .lock     (lock)
  );

  always_ff @(posedge fpga_clk_i or posedge reset_i) begin
    if (reset_i) state <= S_IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (abort_i && state != S_IDLE) begin
      state_nx = S_IDLE;
    end else begin
      case (state)
        S_IDLE, S_DONE: if (start_i)                 state_nx = S_FLUSH;
        S_FLUSH:        if (flush_end)               state_nx = S_ACQUIRE;
        S_ACQUIRE:      if (lock || cnt_full)        state_nx = S_REPORT;
        S_REPORT:       if (result.result_ready_i)   state_nx = S_NEXT;
        S_NEXT:         state_nx = (ki_wrap && kp_end) ? S_DONE : S_FLUSH;
        default:        state_nx = S_IDLE;
      endcase
    end
  end

  // Outputs are registered from the next state so they line up with the state change.
  always_ff @(posedge fpga_clk_i or posedge reset_i) begin
    if (reset_i) begin
      kp_sel                  <= '0;
      ki_sel                  <= '0;
      kp_last                 <= '0;
      ki_last                 <= '0;
      cnt                     <= '0;
      adpll_enable_o          <= 1'b0;
      busy_o                  <= 1'b0;
      done_o                  <= 1'b0;
      result.result_valid_o   <= 1'b0;
      result.result_kp_o      <= '0;
      result.result_ki_o      <= '0;
      result.result_time_o    <= '0;
      result.result_timeout_o <= 1'b0;
    end else begin
      if (sweep_start) begin
        kp_sel  <= '0;
        ki_sel  <= '0;
        kp_last <= kp_last_i;
        ki_last <= ki_last_i;
      end else if (state == S_NEXT && state_nx != S_IDLE) begin
        if (!ki_wrap) begin
          ki_sel <= ki_sel + SEL_WIDTH'(1);
        end else if (!kp_end) begin
          ki_sel <= '0;
          kp_sel <= kp_sel + SEL_WIDTH'(1);
        end
      end

      if (state_nx == state && (state == S_FLUSH || state == S_ACQUIRE))
        cnt <= cnt + CNT_WIDTH'(1);
      else
        cnt <= '0;

      if (state == S_ACQUIRE && state_nx == S_REPORT) begin
        result.result_kp_o      <= kp_sel;
        result.result_ki_o      <= ki_sel;
        result.result_time_o    <= lock ? run_start : '1;
        result.result_timeout_o <= !lock;
      end

      adpll_enable_o        <= (state_nx == S_ACQUIRE) || (state_nx == S_REPORT);
      busy_o                <= (state_nx != S_IDLE) && (state_nx != S_DONE);
      done_o                <= (state_nx == S_DONE);
      result.result_valid_o <= (state_nx == S_REPORT);
    end
  end

endmodule

// File: tb/tb_adpll_gain_sweep.sv
// Directed bench for adpll_gain_sweep: grid order, lock timing, glitch restart,
// timeout on a narrow counter, back-pressure, abort and async reset.
module tb_adpll_gain_sweep;

  logic              clk = 1'b0;
  logic              rst;
  logic              start, abort;
  logic [3:0]        kp_last, ki_last;
  logic signed [7:0] err;
  logic              en, busy, done;
  logic [4:0]        kp_o;
  logic [7:0]        ki_o;

  logic              t_start;
  logic signed [7:0] t_err;
  logic              t_en, t_busy, t_done;
  logic [4:0]        t_kp;
  logic [7:0]        t_ki;

  int n_checks = 0;
  int n_errors = 0;
  int dis, lat;
  logic [31:0] held_time;

  adpll_gain_sweep_if #(.SEL_WIDTH(4), .CNT_WIDTH(24)) res_if ();
  adpll_gain_sweep_if #(.SEL_WIDTH(4), .CNT_WIDTH(8))  t_if ();

  always #2 clk = ~clk;

  adpll_gain_sweep #(.CNT_WIDTH(24)) dut (
    .fpga_clk_i(clk), .reset_i(rst), .start_i(start), .abort_i(abort),
    .kp_last_i(kp_last), .ki_last_i(ki_last), .error_i(err),
    .adpll_enable_o(en), .kp_o(kp_o), .ki_o(ki_o),
    .busy_o(busy), .done_o(done), .result(res_if.master)
  );

  adpll_gain_sweep #(.CNT_WIDTH(8)) dut_t (
    .fpga_clk_i(clk), .reset_i(rst), .start_i(t_start), .abort_i(1'b0),
    .kp_last_i(4'd0), .ki_last_i(4'd0), .error_i(t_err),
    .adpll_enable_o(t_en), .kp_o(t_kp), .ki_o(t_ki),
    .busy_o(t_busy), .done_o(t_done), .result(t_if.master)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic kick(input logic [3:0] kl, input logic [3:0] il);
    kp_last = kl;
    ki_last = il;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
  endtask

  // Called on a negedge; counts disabled cycles, then drives error_i per
  // ACQUIRE cycle index until the record appears. lat = cycles from enable to valid.
  task automatic acquire(input int bad_from, input int bad_to,
                         input logic signed [7:0] bad_val, input logic signed [7:0] good_val,
                         output int n_dis, output int n_lat);
    n_dis = 0;
    n_lat = 0;
    while (!en && n_dis < 5000) begin
      n_dis++;
      @(negedge clk);
    end
    if (!en) begin
      chk("enable_wait", 32'd0, 32'd1);
      return;
    end
    while (!res_if.result_valid_o && n_lat < 5000) begin
      err = (n_lat >= bad_from && n_lat < bad_to) ? bad_val : good_val;
      n_lat++;
      @(negedge clk);
    end
    if (!res_if.result_valid_o) chk("valid_wait", 32'd0, 32'd1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; kp_last = '0; ki_last = '0; err = '0;
    t_start = 1'b0; t_err = '0;
    res_if.result_ready_i = 1'b1;
    t_if.result_ready_i   = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    chk("rst_enable", en, 0);
    chk("rst_kp", kp_o, 0);
    chk("rst_ki", ki_o, 0);
    chk("rst_valid", res_if.result_valid_o, 0);
    chk("rst_time", res_if.result_time_o, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);

    // Single point, error always zero: minimum lock time.
    kick(4'd0, 4'd0);
    chk("busy_after_start", busy, 1);
    acquire(0, 0, 8'sd0, 8'sd0, dis, lat);
    chk("p1_flush", dis, 64);
    chk("p1_latency", lat, 1025);
    chk("p1_time", res_if.result_time_o, 0);
    chk("p1_timeout", res_if.result_timeout_o, 0);
    chk("p1_kp", res_if.result_kp_o, 0);
    chk("p1_ki", res_if.result_ki_o, 0);
    @(negedge clk);
    chk("p1_valid_drop", res_if.result_valid_o, 0);
    @(negedge clk);
    chk("p1_done", done, 1);
    chk("p1_done_en", en, 0);
    chk("p1_done_busy", busy, 0);
    chk("p1_done_kp", kp_o, 0);
    chk("p1_done_ki", ki_o, 0);

    // 2x3 grid from DONE, ready held high.
    kick(4'd1, 4'd2);
    chk("grid_done_clr", done, 0);
    for (int p = 0; p < 6; p++) begin
      acquire(0, 0, 8'sd0, 8'sd0, dis, lat);
      chk("grid_kp", res_if.result_kp_o, p / 3);
      chk("grid_ki", res_if.result_ki_o, p % 3);
      chk("grid_flush", dis, (p == 0) ? 64 : 65);
      chk("grid_time", res_if.result_time_o, 0);
      @(negedge clk);
    end
    @(negedge clk);
    chk("grid_done", done, 1);
    chk("grid_done_kp", kp_o, 1);

    // Out-of-window for 300 cycles, then a boundary-level error with one glitch.
    kick(4'd0, 4'd1);
    acquire(0, 300, 8'sd20, 8'sd0, dis, lat);
    chk("late_time", res_if.result_time_o, 300);
    chk("late_latency", lat, 1325);
    chk("late_timeout", res_if.result_timeout_o, 0);
    @(negedge clk);
    acquire(500, 501, -8'sd5, 8'sd4, dis, lat);
    chk("glitch_time", res_if.result_time_o, 501);
    chk("glitch_ki", res_if.result_ki_o, 1);
    chk("glitch_latency", lat, 1526);
    @(negedge clk);
    @(negedge clk);
    chk("glitch_done", done, 1);

    // Back-pressure, then abort during REPORT.
    res_if.result_ready_i = 1'b0;
    kick(4'd0, 4'd2);
    acquire(0, 0, 8'sd0, 8'sd0, dis, lat);
    held_time = 32'(res_if.result_time_o);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_valid", res_if.result_valid_o, 1);
      chk("bp_time", res_if.result_time_o, held_time);
    end
    chk("bp_ki", res_if.result_ki_o, 0);
    res_if.result_ready_i = 1'b1;
    @(negedge clk);
    res_if.result_ready_i = 1'b0;
    chk("bp_valid_drop", res_if.result_valid_o, 0);
    acquire(0, 0, 8'sd0, 8'sd0, dis, lat);
    chk("ab_ki_before", res_if.result_ki_o, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("ab_valid", res_if.result_valid_o, 0);
    chk("ab_busy", busy, 0);
    chk("ab_en", en, 0);
    @(negedge clk);
    chk("ab_no_next", ki_o, 1);
    chk("ab_done", done, 0);

    // Async reset during the second point's ACQUIRE.
    res_if.result_ready_i = 1'b1;
    kick(4'd1, 4'd0);
    acquire(0, 0, 8'sd0, 8'sd0, dis, lat);
    @(negedge clk);
    dis = 0;
    while (!en && dis < 200) begin
      dis++;
      @(negedge clk);
    end
    repeat (100) @(negedge clk);
    chk("pre_rst_kp", kp_o, 1);
    chk("pre_rst_en", en, 1);
    #0.5 rst = 1'b1;
    #0.5;
    chk("arst_en", en, 0);
    chk("arst_kp", kp_o, 0);
    chk("arst_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    kick(4'd1, 4'd0);
    chk("restart_kp", kp_o, 0);
    acquire(0, 0, 8'sd0, 8'sd0, dis, lat);
    chk("restart_rec_kp", res_if.result_kp_o, 0);
    chk("restart_time", res_if.result_time_o, 0);
    @(negedge clk);

    // Narrow counter with the most-negative error: must time out.
    t_err   = -8'sd128;
    t_start = 1'b1;
    @(negedge clk);
    t_start = 1'b0;
    lat = 0;
    while (!t_if.result_valid_o && lat < 2000) begin
      lat++;
      @(negedge clk);
    end
    chk("to_valid", t_if.result_valid_o, 1);
    chk("to_timeout", t_if.result_timeout_o, 1);
    chk("to_time", t_if.result_time_o, 255);
    chk("to_wait", lat, 64 + 256);
    repeat (2) @(negedge clk);
    chk("to_done", t_done, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/adpll_gain_sweep.md
# adpll_gain_sweep

Sequencer that steps the ADPLL proportional and integral gain selectors through a programmed grid. For each (kp, ki) point it flushes the loop, enables it, measures cycles to lock from the phase-error output, and reports one result record per point through a valid/ready handshake. It sits beside the ADPLL in the fpga_clk_i (258 MHz) domain. It replaces the static switch-driven kp/ki/enable wiring in gain-test builds.

## Interface
- KP_WIDTH, 5, width of kp_o (selector zero-extended)
- KI_WIDTH, 8, width of ki_o (selector zero-extended)
- SEL_WIDTH, 4, width of kp/ki grid selectors
- ERR_WIDTH, 8, width of signed ADPLL phase error
- LOCK_THRESH, 4, lock window: |error| <= LOCK_THRESH
- LOCK_COUNT, 1024, consecutive in-window cycles required to declare lock
- FLUSH_CYCLES, 64, cycles ADPLL held disabled before each point
- CNT_WIDTH, 24, lock-time counter width; timeout at 2^CNT_WIDTH-1

- fpga_clk_i  in  1  ADPLL/system clock
- reset_i  in  1  asynchronous, active-high reset
- start_i  in  1  begin sweep (sampled in IDLE or DONE only)
- abort_i  in  1  abandon sweep, return to IDLE
- kp_last_i  in  SEL_WIDTH  final kp selector (sweep 0..kp_last_i)
- ki_last_i  in  SEL_WIDTH  final ki selector (sweep 0..ki_last_i)
- error_i  in  ERR_WIDTH  signed ADPLL phase error, synchronous to fpga_clk_i
- adpll_enable_o  out  1  ADPLL enable
- kp_o  out  KP_WIDTH  {zeros, kp_sel}
- ki_o  out  KI_WIDTH  {zeros, ki_sel}
- result_valid_o  out  1  result record valid
- result_ready_i  in  1  consumer accepts record
- result_kp_o, result_ki_o  out  SEL_WIDTH  selectors of reported point
- result_time_o  out  CNT_WIDTH  cycle count from enable to lock-run start
- result_timeout_o  out  1  point failed to lock
- busy_o  out  1  sweep in progress (not IDLE/DONE)
- done_o  out  1  sweep finished

## Operation
- States: IDLE, FLUSH, ACQUIRE, REPORT, NEXT, DONE.
- IDLE: start_i=1 -> FLUSH with kp_sel=0, ki_sel=0.
- FLUSH: adpll_enable_o=0, counter counts FLUSH_CYCLES, then -> ACQUIRE with cycle counter cleared.
- ACQUIRE: adpll_enable_o=1; cycle counter increments each cycle. |error_i| is computed at ERR_WIDTH+1 bits, so the most-negative value does not overflow. In-window cycles increment the run counter. An out-of-window cycle clears it and sets run_start = current cycle count + 1. When run reaches LOCK_COUNT: record result_time=run_start, timeout=0, -> REPORT. If the cycle counter reaches all-ones first: result_time=all-ones, timeout=1, -> REPORT.
- REPORT: adpll_enable_o=1, result_valid_o=1, record stable until result_ready_i=1 on a clock edge, then -> NEXT.
- NEXT: if ki_sel<ki_last_i, ki_sel++. Else ki_sel=0; if kp_sel<kp_last_i, kp_sel++; else -> DONE. Otherwise -> FLUSH.
- DONE: done_o=1, adpll_enable_o=0, kp/ki hold last point; start_i=1 -> FLUSH from (0,0) and clears done_o.
- abort_i in any non-IDLE state -> IDLE next cycle. It drops result_valid_o without a transfer. abort_i has priority over start_i and the handshake.
- start_i ignored outside IDLE/DONE. kp_last_i/ki_last_i sampled only at sweep start.

## Timing
- All outputs are registered. Reset value of every output is 0, including kp_o, ki_o, result_*, and state IDLE.
- start_i at edge N: FLUSH from N+1. kp_o/ki_o are updated at N+1 and are stable at least FLUSH_CYCLES before enable rises.
- adpll_enable_o rises on the first ACQUIRE cycle. error_i is evaluated from that cycle, and cycle count 0 corresponds to it.
- Minimum lock: an in-window error from the first ACQUIRE cycle gives result_time=0 and result_valid_o LOCK_COUNT+1 cycles after entering ACQUIRE.
- Handshake: transfer on an edge with valid&ready. valid deasserts the next cycle. Ready may be held high permanently, giving a 1-cycle REPORT.
- Reset mid-sweep clears everything asynchronously. adpll_enable_o goes low immediately.

## Structure
- Shared package/header adpll_ctrl_pkg: state encoding, gain-selector pad widths, default LOCK_THRESH/LOCK_COUNT.
- One sub-module, adpll_lock_detect: abs-error window compare, run counter, run_start capture, lock pulse. Cleared on entry to ACQUIRE.

## Test plan
- kp_last=0, ki_last=0, error_i=0 constantly -> one record (0,0), time=0, timeout=0, then done_o=1, adpll_enable_o=0.
- kp_last=1, ki_last=2, ready held high -> 6 records in order (0,0),(0,1),(0,2),(1,0),(1,1),(1,2). Each is preceded by 64 disabled cycles.
- error_i=20 for 300 ACQUIRE cycles, then 0 -> time=300 after LOCK_COUNT in-window cycles. A single out-of-window glitch restarts the run and the time.
- error_i=-128 constantly, CNT_WIDTH=8 -> timeout=1, time=255. The abs does not alias into the window.
- ready low for 10 cycles during REPORT -> record fields stable and valid held; abort_i during REPORT -> IDLE, valid drops, no NEXT.
- reset_i pulsed mid-ACQUIRE -> all outputs 0 asynchronously; a subsequent start_i restarts at (0,0).
